// File: rtl/qpsk_pkg.sv
// Shared types for the QPSK frame capture block: FSM state encoding and
// the quadrant index of a signed I/Q sample.
package qpsk_pkg;

  typedef enum logic [2:0] {
    ST_HUNT     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_GUARD    = 3'd2,
    ST_DATA     = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  typedef logic [1:0] quad_t;

  // Quadrant from the sign bits only; zero counts as non-negative.
  function automatic quad_t quadrant(input logic i_neg, input logic q_neg);
    case ({i_neg, q_neg})
      2'b00:   return 2'd0;
      2'b10:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/symbol_packer.sv
// Packs 2-bit symbols LSB-first into BRAM words and generates the write
// strobe and the incrementing, wrapping write address.
module symbol_packer
  import qpsk_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int BRAM_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  sym_valid_i,
  input  quad_t                 sym_i,
  input  logic                  flush_i,
  output logic [ADDR_WIDTH-1:0] bram_addr_o,
  output logic                  bram_wea_o,
  output logic [BRAM_WIDTH-1:0] bram_dina_o,
  output logic                  emit_o,
  output logic                  wrap_o
);

  localparam int SPW = BRAM_WIDTH / 2;
  localparam int CW  = (SPW > 1) ? $clog2(SPW) : 1;

  logic [CW-1:0]         cnt_q;
  logic [BRAM_WIDTH-1:0] buf_q;
  logic [BRAM_WIDTH-1:0] word_d;
  logic [ADDR_WIDTH-1:0] next_addr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BRAM_WIDTH-1:0] dina_q;
  logic                  wea_q;
  logic                  emit;

  always_comb begin
    word_d = buf_q;
    word_d[{cnt_q, 1'b0} +: 2] = sym_i;
  end

  // A short final word is emitted by flush with its unused upper symbols still zero.
  assign emit   = sym_valid_i && ((cnt_q == CW'(SPW - 1)) || flush_i);
  assign wrap_o = emit && (next_addr_q == '1);
  assign emit_o = emit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      buf_q       <= '0;
      next_addr_q <= '0;
      addr_q      <= '0;
      dina_q      <= '0;
      wea_q       <= 1'b0;
    end else begin
      wea_q <= 1'b0;
      if (clear_i) begin
        cnt_q       <= '0;
        buf_q       <= '0;
        next_addr_q <= '0;
      end else if (sym_valid_i) begin
        if (emit) begin
          wea_q       <= 1'b1;
          dina_q      <= word_d;
          addr_q      <= next_addr_q;
          next_addr_q <= next_addr_q + ADDR_WIDTH'(1);
          cnt_q       <= '0;
          buf_q       <= '0;
        end else begin
          buf_q <= word_d;
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign bram_addr_o = addr_q;
  assign bram_wea_o  = wea_q;
  assign bram_dina_o = dina_q;

endmodule

// File: rtl/qpsk_frame_capture.sv
// QPSK frame capture: decimates AXI-stream I/Q samples to symbols, locks on a
// preamble and guard interval, then stores rotation-corrected data symbols.
module qpsk_frame_capture
  import qpsk_pkg::*;
#(
  parameter int TDATA_WIDTH  = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int BRAM_WIDTH   = 8,
  parameter int PREAMBLE_LEN = 4,
  parameter int GUARD_LEN    = 3
) (
  input  logic                     s00_axis_aclk,
  input  logic                     s00_axis_aresetn,
  input  logic                     s00_axis_tvalid,
  input  logic [TDATA_WIDTH-1:0]   s00_axis_tdata,
  output logic                     s00_axis_tready,
  input  logic                     cfg_enable,
  input  logic [TDATA_WIDTH/2-1:0] cfg_allowed_error,
  input  logic [15:0]              cfg_num_samples,
  input  logic [ADDR_WIDTH+3:0]    cfg_data_len,
  output logic [ADDR_WIDTH-1:0]    bram_addr,
  output logic                     bram_wea,
  output logic [BRAM_WIDTH-1:0]    bram_dina,
  output logic                     frame_done,
  output logic [ADDR_WIDTH:0]      frame_words,
  output logic                     overflow,
  output logic [2:0]               state_dbg
);

  localparam int HW  = TDATA_WIDTH / 2;
  localparam int DLW = ADDR_WIDTH + 4;
  localparam int FWW = ADDR_WIDTH + 1;
  localparam int PCW = $clog2(PREAMBLE_LEN + 1);
  localparam int GCW = $clog2(GUARD_LEN + 1);

  state_e          state_q;
  logic            tready_q;
  logic [15:0]     sps_q;
  logic [15:0]     beat_cnt_q;
  logic [HW-1:0]   tol_q;
  logic [HW-1:0]   ref_i_q;
  logic [HW-1:0]   ref_q_q;
  logic [DLW-1:0]  data_rem_q;
  logic [PCW-1:0]  pre_cnt_q;
  logic [GCW-1:0]  guard_cnt_q;
  logic [FWW-1:0]  words_q;
  logic [FWW-1:0]  frame_words_q;
  logic            frame_done_q;
  logic            overflow_q;

  logic [HW-1:0]   s_i, s_q;
  logic [HW:0]     d_i, d_q, a_i, a_q, g_i, g_q, tol_x;
  logic            match, quiet;
  logic [15:0]     sps_cfg, sps_eff;
  logic            window_idle, take, is_symbol, beat_adv, beat_last;
  quad_t           sym_rel;
  logic            pk_emit, pk_wrap;

  assign s_i = s00_axis_tdata[TDATA_WIDTH-1:HW];
  assign s_q = s00_axis_tdata[HW-1:0];

  // Differences carry one extra bit so full-scale opposite samples cannot wrap into a match.
  assign d_i   = {s_i[HW-1], s_i} - {ref_i_q[HW-1], ref_i_q};
  assign d_q   = {s_q[HW-1], s_q} - {ref_q_q[HW-1], ref_q_q};
  assign a_i   = d_i[HW] ? -d_i : d_i;
  assign a_q   = d_q[HW] ? -d_q : d_q;
  assign g_i   = s_i[HW-1] ? -{1'b1, s_i} : {1'b0, s_i};
  assign g_q   = s_q[HW-1] ? -{1'b1, s_q} : {1'b0, s_q};
  assign tol_x = {1'b0, tol_q};
  assign match = (a_i < tol_x) && (a_q < tol_x);
  assign quiet = (g_i < tol_x) && (g_q < tol_x);

  // Windows only start while a frame is armed or running; trailing beats of a window always finish.
  assign sps_cfg     = (cfg_num_samples == 16'd0) ? 16'd1 : cfg_num_samples;
  assign window_idle = (beat_cnt_q == 16'd0);
  assign sps_eff     = (state_q == ST_HUNT && window_idle) ? sps_cfg : sps_q;
  assign take        = (state_q == ST_PREAMBLE) || (state_q == ST_GUARD) ||
                       (state_q == ST_DATA) || (state_q == ST_HUNT && cfg_enable);
  assign is_symbol   = s00_axis_tvalid && window_idle && take;
  assign beat_adv    = s00_axis_tvalid && (!window_idle || take);
  assign beat_last   = (beat_cnt_q == sps_eff - 16'd1);

  assign sym_rel = quadrant(s_i[HW-1], s_q[HW-1]) - quadrant(ref_i_q[HW-1], ref_q_q[HW-1]);

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q       <= ST_HUNT;
      tready_q      <= 1'b0;
      sps_q         <= 16'd1;
      beat_cnt_q    <= '0;
      tol_q         <= '0;
      ref_i_q       <= '0;
      ref_q_q       <= '0;
      data_rem_q    <= '0;
      pre_cnt_q     <= '0;
      guard_cnt_q   <= '0;
      words_q       <= '0;
      frame_words_q <= '0;
      frame_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      tready_q     <= 1'b1;
      frame_done_q <= 1'b0;
      if (beat_adv) beat_cnt_q <= beat_last ? 16'd0 : beat_cnt_q + 16'd1;
      if (pk_wrap) overflow_q <= 1'b1;
      if (pk_emit) words_q <= words_q + FWW'(1);
      case (state_q)
        ST_HUNT: begin
          if (is_symbol) begin
            ref_i_q    <= s_i;
            ref_q_q    <= s_q;
            sps_q      <= sps_cfg;
            tol_q      <= cfg_allowed_error;
            data_rem_q <= cfg_data_len;
            pre_cnt_q  <= PCW'(PREAMBLE_LEN - 1);
            overflow_q <= 1'b0;
            words_q    <= '0;
            state_q    <= ST_PREAMBLE;
          end
        end
        ST_PREAMBLE: begin
          if (is_symbol) begin
            if (!match) begin
              state_q <= ST_HUNT;
            end else if (pre_cnt_q == PCW'(1)) begin
              guard_cnt_q <= GCW'(GUARD_LEN);
              state_q     <= ST_GUARD;
            end else begin
              pre_cnt_q <= pre_cnt_q - PCW'(1);
            end
          end
        end
        ST_GUARD: begin
          if (is_symbol) begin
            if (!quiet) begin
              state_q <= ST_HUNT;
            end else if (guard_cnt_q == GCW'(1)) begin
              if (data_rem_q == '0) begin
                frame_done_q  <= 1'b1;
                frame_words_q <= words_q;
                state_q       <= ST_DONE;
              end else begin
                state_q <= ST_DATA;
              end
            end else begin
              guard_cnt_q <= guard_cnt_q - GCW'(1);
            end
          end
        end
        ST_DATA: begin
          if (is_symbol) begin
            data_rem_q <= data_rem_q - DLW'(1);
            if (data_rem_q == DLW'(1)) begin
              frame_done_q  <= 1'b1;
              frame_words_q <= words_q + FWW'(1);
              state_q       <= ST_DONE;
            end
          end
        end
        default: state_q <= ST_HUNT;
      endcase
    end
  end

  symbol_packer #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .BRAM_WIDTH(BRAM_WIDTH)
  ) u_packer (
    .clk_i      (s00_axis_aclk),
    .rst_ni     (s00_axis_aresetn),
    .clear_i    (state_q == ST_HUNT && is_symbol),
    .sym_valid_i(state_q == ST_DATA && is_symbol),
    .sym_i      (sym_rel),
    .flush_i    (data_rem_q == DLW'(1)),
    .bram_addr_o(bram_addr),
    .bram_wea_o (bram_wea),
    .bram_dina_o(bram_dina),
    .emit_o     (pk_emit),
    .wrap_o     (pk_wrap)
  );

  assign s00_axis_tready = tready_q;
  assign frame_done      = frame_done_q;
  assign frame_words     = frame_words_q;
  assign overflow        = overflow_q;
  assign state_dbg       = state_q;

endmodule
